servo_pulse_decoder: RTL and testbench
======================================

# servo_pulse_decoder

Receive-side counterpart to the servo PWM generator. It measures the high time of an incoming 20 ms servo-style PWM signal, for example from an RC receiver or a looped-back generator output on a PMOD pin. It reports the width in clock cycles and a clamped position value. Pulses out of range are flagged, and loss of signal is detected. It sits between a PMOD input pin and the control logic, in the 25 MHz `i_Clk` domain.

## Interface
- `MIN_PULSE`, 12500: shortest accepted high time, in cycles (0.5 ms).
- `MAX_PULSE`, 62500: longest accepted high time, in cycles (2.5 ms).
- `POS_MIN`, 25000: width that maps to position 0 (1 ms).
- `POS_SPAN`, 25000: position full scale (2 ms maps to 25000).
- `TIMEOUT`, 625000: cycles without a rising edge before signal-lost is raised (25 ms).
- `FILTER_LEN`, 8: glitch filter stability length, in cycles (used only with the macro).
- `i_Clk` in 1: system clock, 25 MHz.
- `i_Rst_L` in 1: asynchronous active-low reset.
- `i_Servo` in 1: asynchronous PWM input pin.
- `o_Width` out 16: last accepted high time, in cycles.
- `o_Position` out 16: clamp(`o_Width` − `POS_MIN`, 0, `POS_SPAN`).
- `o_Valid` out 1: one-cycle strobe when `o_Width`/`o_Position` update.
- `o_Error` out 1: one-cycle strobe when a pulse is rejected.
- `o_Lost` out 1: level, high while no signal is present.

## Operation
- **Input path:** 2-flop synchronizer, then the optional filter, then an edge-detect register. All three reset to 1, so a line that is already high at reset produces no false rising edge.
- **State: IDLE.** Reset state. Waits for a rising edge, then clears the width counter to 1 and moves to HIGH.
- **State: HIGH.** The width counter increments each cycle the level is high.
  - Falling edge with `MIN_PULSE` ≤ count ≤ `MAX_PULSE`: latch `o_Width`, compute `o_Position`, pulse `o_Valid`, clear `o_Lost`, go to LOW.
  - Falling edge with count < `MIN_PULSE`: pulse `o_Error`, outputs held, go to LOW.
  - Count reaching `MAX_PULSE`+1 while still high: pulse `o_Error` once, go to STUCK.
- **State: LOW.** Waits for a rising edge, then restarts the counter and goes to HIGH.
- **State: STUCK.** Waits for a falling edge, then goes to LOW. Nothing is measured in this state.
- **Timeout counter:** 20-bit. It clears on every rising edge, increments otherwise, and saturates at `TIMEOUT`.
  - Reaching `TIMEOUT` sets `o_Lost` in any state and forces IDLE.
  - `o_Lost` clears only on an accepted pulse.
- **Arithmetic:** the width counter is 17-bit internally so it cannot wrap before the `MAX_PULSE`+1 check. The position subtraction is 17-bit signed and clamped low at 0 and high at `POS_SPAN`.
- **Simultaneous events:** the timeout terminal count and an edge in the same cycle are resolved in favour of the edge.
- **Reset mid-pulse:** the partial pulse is discarded, the block returns to IDLE, and `o_Lost`=1.

## Timing
- **Reset values:** `o_Width`=0, `o_Position`=0, `o_Valid`=0, `o_Error`=0, `o_Lost`=1.
- **Edge latency:** an edge on the pin is seen by the FSM 3 cycles later, or 3+`FILTER_LEN` cycles later with the filter. Both edges are delayed equally, so the measured width equals the true width ±1 cycle.
- **Output latency:** `o_Valid` asserts the cycle after the FSM sees the falling edge. `o_Width` and `o_Position` are valid in that same cycle and are held until the next accepted pulse.
- **Strobes:** `o_Valid` and `o_Error` are never high in the same cycle, and each lasts exactly 1 cycle.

## Configuration
- **`SERVO_DEC_GLITCH_FILTER_EN` defined:** the filtered level changes only after the synchronized input has held its new value for `FILTER_LEN` consecutive cycles. Shorter glitches are ignored entirely.
- **`SERVO_DEC_GLITCH_FILTER_EN` undefined:** the filter is removed, the synchronized level feeds the edge detector directly, and `FILTER_LEN` is unused.

## Structure
- **Shared package `servo_pkg`:**
  - timing constants (clock rate, cycles per µs/ms, default MIN/MAX/POS/TIMEOUT values), shared with the generator;
  - FSM state enum `{IDLE, HIGH, LOW, STUCK}`.
- **Sub-module `servo_glitch_filter`:** the optional level-stability filter, with its own counter, instantiated only under the macro.

## Test plan
- **Nominal 1.5 ms pulse:** 37500-cycle high, 462500 low, repeated → `o_Valid` each period, `o_Width`=37500 (±1), `o_Position`=12500, `o_Lost` falls after the first pulse.
- **Clamping:** 0.8 ms (20000) → `o_Position`=0; 2.2 ms (55000) → `o_Position`=25000; both strobe `o_Valid`.
- **Rejection:** 0.2 ms (5000) pulse → `o_Error` strobe, outputs unchanged. A 3 ms high → `o_Error` at count 62501, STUCK, then normal measurement resumes on the next pulse.
- **Loss of signal:** input held low for 25 ms after valid pulses → `o_Lost`=1 at cycle 625000 after the last rising edge. The next valid pulse clears it.
- **Reset mid-pulse:** assert `i_Rst_L` low 10000 cycles into a high pulse → all outputs at reset values, and no `o_Valid` for that partial pulse.
- **Glitch filter (macro defined):** 3-cycle low glitches inside a 37500-cycle pulse → one `o_Valid` with width 37500. With the macro undefined, the same stimulus → `o_Error` strobes.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo timing constants and decoder FSM state type.
package servo_pkg;

  localparam int unsigned CLK_HZ     = 25_000_000;
  localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
  localparam int unsigned CYC_PER_MS = CYC_PER_US * 1000;

  localparam int unsigned DEF_MIN_PULSE  = CYC_PER_MS / 2;        // 0.5 ms
  localparam int unsigned DEF_MAX_PULSE  = (CYC_PER_MS * 5) / 2;  // 2.5 ms
  localparam int unsigned DEF_POS_MIN    = CYC_PER_MS;            // 1.0 ms
  localparam int unsigned DEF_POS_SPAN   = CYC_PER_MS;            // 1.0 ms full scale
  localparam int unsigned DEF_TIMEOUT    = CYC_PER_MS * 25;       // 25 ms
  localparam int unsigned DEF_FILTER_LEN = 8;

  localparam int unsigned WIDTH_W = 16;  // reported width / position
  localparam int unsigned CNT_W   = 17;  // width counter, room for MAX+1
  localparam int unsigned TO_W    = 20;  // loss-of-signal counter

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    STUCK
  } servo_state_e;

endpackage

// File: rtl/servo_pulse_decoder_if.sv
// Result bundle of the servo pulse decoder.
interface servo_pulse_decoder_if;
  import servo_pkg::*;

  logic [WIDTH_W-1:0] o_Width;
  logic [WIDTH_W-1:0] o_Position;
  logic               o_Valid;
  logic               o_Error;
  logic               o_Lost;

  modport master (
    output o_Width,
    output o_Position,
    output o_Valid,
    output o_Error,
    output o_Lost
  );

  modport slave (
    input o_Width,
    input o_Position,
    input o_Valid,
    input o_Error,
    input o_Lost
  );
endinterface

// File: rtl/servo_glitch_filter.sv
// Level-stability filter: output follows input only after FILTER_LEN
// consecutive cycles at the new value. Resets high like the sync chain.
module servo_glitch_filter
  import servo_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Level,
  output logic o_Level
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] stable_cnt;

  // Count cycles the input disagrees with the output; commit on the Nth.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Level    <= 1'b1;
      stable_cnt <= '0;
    end else if (i_Level == o_Level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
      o_Level    <= i_Level;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo PWM pulse-width decoder: measures high time, clamps a position,
// flags out-of-range pulses and detects loss of signal.
// Optional glitch filter enabled by defining SERVO_DEC_GLITCH_FILTER_EN.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned MIN_PULSE  = DEF_MIN_PULSE,
  parameter int unsigned MAX_PULSE  = DEF_MAX_PULSE,
  parameter int unsigned POS_MIN    = DEF_POS_MIN,
  parameter int unsigned POS_SPAN   = DEF_POS_SPAN,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Servo,
  servo_pulse_decoder_if.master  bus
);

  logic sync_1, sync_2;
  logic level, level_q;
  logic rise, fall;

  servo_state_e       state, state_nxt;
  logic [CNT_W-1:0]   width_cnt, width_cnt_nxt;
  logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
  logic [WIDTH_W-1:0] width_q, width_nxt;
  logic [WIDTH_W-1:0] pos_q, pos_nxt;
  logic               valid_q, valid_nxt;
  logic               error_q, error_nxt;
  logic               lost_q, lost_nxt;
  logic signed [CNT_W-1:0] pos_diff;

  // Two-flop synchronizer, reset high so an idle-high line gives no edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= i_Servo;
      sync_2 <= sync_1;
    end
  end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
  servo_glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Level (sync_2),
    .o_Level (level)
  );
`else
  logic unused_filter_len;
  assign unused_filter_len = ^FILTER_LEN;
  assign level             = sync_2;
`endif

  // Edge-detect register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) level_q <= 1'b1;
    else          level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

  // State and result registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      width_cnt <= '0;
      to_cnt    <= '0;
      width_q   <= '0;
      pos_q     <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      lost_q    <= 1'b1;
    end else begin
      state     <= state_nxt;
      width_cnt <= width_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      width_q   <= width_nxt;
      pos_q     <= pos_nxt;
      valid_q   <= valid_nxt;
      error_q   <= error_nxt;
      lost_q    <= lost_nxt;
    end
  end

  // Next-state, measurement and timeout logic.
  always_comb begin
    state_nxt     = state;
    width_cnt_nxt = width_cnt;
    to_cnt_nxt    = to_cnt;
    width_nxt     = width_q;
    pos_nxt       = pos_q;
    valid_nxt     = 1'b0;
    error_nxt     = 1'b0;
    lost_nxt      = lost_q;
    pos_diff      = $signed(width_cnt) - $signed(CNT_W'(POS_MIN));

    if (rise)                             to_cnt_nxt = '0;
    else if (to_cnt < TO_W'(TIMEOUT))     to_cnt_nxt = to_cnt + TO_W'(1);

    case (state)
      IDLE, LOW: begin
        if (rise) begin
          width_cnt_nxt = CNT_W'(1);
          state_nxt     = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          state_nxt = LOW;
          if (width_cnt >= CNT_W'(MIN_PULSE) && width_cnt <= CNT_W'(MAX_PULSE)) begin
            width_nxt = WIDTH_W'(width_cnt);
            if (pos_diff < 0)
              pos_nxt = '0;
            else if (pos_diff > $signed(CNT_W'(POS_SPAN)))
              pos_nxt = WIDTH_W'(POS_SPAN);
            else
              pos_nxt = WIDTH_W'(pos_diff);
            valid_nxt = 1'b1;
            lost_nxt  = 1'b0;
          end else begin
            error_nxt = 1'b1;
          end
        end else begin
          width_cnt_nxt = width_cnt + CNT_W'(1);
          if (width_cnt == CNT_W'(MAX_PULSE)) begin
            error_nxt = 1'b1;
            state_nxt = STUCK;
          end
        end
      end
      STUCK: begin
        if (fall) state_nxt = LOW;
      end
      default: state_nxt = IDLE;
    endcase

    // Loss of signal; an edge in the same cycle takes priority.
    if (!rise && !fall && to_cnt_nxt == TO_W'(TIMEOUT)) begin
      state_nxt = IDLE;
      lost_nxt  = 1'b1;
    end
  end

  assign bus.o_Width    = width_q;
  assign bus.o_Position = pos_q;
  assign bus.o_Valid    = valid_q;
  assign bus.o_Error    = error_q;
  assign bus.o_Lost     = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder with scaled-down timing.
module tb_servo_pulse_decoder;

  localparam int MIN_P  = 50;
  localparam int MAX_P  = 250;
  localparam int PMIN_P = 100;
  localparam int PSPN_P = 100;
  localparam int TOUT_P = 1500;
  localparam int FLEN_P = 4;

  typedef struct {
    bit is_err;
    int width;
    int pos;
    bit lost;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic servo = 1'b0;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_width = 0;
  int   m_pos   = 0;
  bit   m_lost  = 1'b1;

  always #5 clk = ~clk;

  servo_pulse_decoder_if bus ();

  servo_pulse_decoder #(
    .MIN_PULSE  (MIN_P),
    .MAX_PULSE  (MAX_P),
    .POS_MIN    (PMIN_P),
    .POS_SPAN   (PSPN_P),
    .TIMEOUT    (TOUT_P),
    .FILTER_LEN (FLEN_P)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .i_Servo (servo),
    .bus     (bus)
  );

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int clamp_pos(input int w);
    int d;
    d = w - PMIN_P;
    if (d < 0)      return 0;
    if (d > PSPN_P) return PSPN_P;
    return d;
  endfunction

  // Reference: classify one high segment and update the model's held outputs.
  task automatic expect_pulse(input int w);
    exp_t e;
    if (w >= MIN_P && w <= MAX_P) begin
      m_width = w;
      m_pos   = clamp_pos(w);
      m_lost  = 1'b0;
      e = '{1'b0, m_width, m_pos, 1'b0};
    end else begin
      e = '{1'b1, m_width, m_pos, m_lost};
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_pulse(input int hi, input int lo);
    @(negedge clk) servo = 1'b1;
    repeat (hi) @(negedge clk);
    servo = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_width"}, int'(bus.o_Width), 0);
    check({tag, "_pos"},   int'(bus.o_Position), 0);
    check({tag, "_valid"}, int'(bus.o_Valid), 0);
    check({tag, "_error"}, int'(bus.o_Error), 0);
    check({tag, "_lost"},  int'(bus.o_Lost), 1);
  endtask

  // Monitor: every strobe is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (bus.o_Valid || bus.o_Error)) begin
      if (bus.o_Valid && bus.o_Error)
        check("strobe_exclusive", 1, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", int'(bus.o_Error), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_kind", int'(bus.o_Error), int'(e.is_err));
        check("width",       int'(bus.o_Width), e.width);
        check("position",    int'(bus.o_Position), e.pos);
        check("lost",        int'(bus.o_Lost), int'(e.lost));
      end
    end
  end

  int directed_w[11] = '{MIN_P - 1, MIN_P, MAX_P, MAX_P + 1, 20, 350,
                         99, 100, 200, 201, 150};

  initial begin
    int w, lo;

    // Reset state
    repeat (5) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // First valid pulse clears lost
    expect_pulse(150);
    drive_pulse(150, 200);
    check("lost_after_first", int'(bus.o_Lost), 0);

    // Boundary and clamp cases
    foreach (directed_w[i]) begin
      expect_pulse(directed_w[i]);
      drive_pulse(directed_w[i], 60);
    end

    // Random pulses
    for (int k = 0; k < 30; k++) begin
      w  = int'($urandom_range(10, 320));
      lo = int'($urandom_range(20, 300));
      expect_pulse(w);
      drive_pulse(w, lo);
    end

    // Loss of signal measured from the last rising edge on the pin
    expect_pulse(120);
    @(negedge clk) servo = 1'b1;
    repeat (120) @(negedge clk);
    servo = 1'b0;
    repeat (TOUT_P - 10 - 120) @(negedge clk);
    check("lost_before_timeout", int'(bus.o_Lost), 0);
    repeat (20) @(negedge clk);
    check("lost_after_timeout", int'(bus.o_Lost), 1);
    m_lost = 1'b1;
    expect_pulse(180);
    drive_pulse(180, 100);
    check("lost_recovered", int'(bus.o_Lost), 0);

    // Short low glitches inside one long pulse
`ifdef SERVO_DEC_GLITCH_FILTER_EN
    expect_pulse(126);
`else
    expect_pulse(40);
    expect_pulse(40);
    expect_pulse(40);
`endif
    @(negedge clk) servo = 1'b1;
    repeat (40) @(negedge clk);
    servo = 1'b0;
    repeat (3) @(negedge clk);
    servo = 1'b1;
    repeat (40) @(negedge clk);
    servo = 1'b0;
    repeat (3) @(negedge clk);
    servo = 1'b1;
    repeat (40) @(negedge clk);
    servo = 1'b0;
    repeat (100) @(negedge clk);

    // Reset in the middle of a pulse discards it
    servo = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("midreset");
    m_width = 0;
    m_pos   = 0;
    m_lost  = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    servo = 1'b0;
    repeat (50) @(negedge clk);
    expect_pulse(MIN_P - 5);
    drive_pulse(MIN_P - 5, 60);
    expect_pulse(210);
    drive_pulse(210, 100);

    repeat (50) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
